// File: rtl/periph_bus_bridge.sv
// Avalon-MM bridge from the CPU data bus to the small-peripheral bus.
// Decodes the peripheral region, registers the access and turns unmapped or hung accesses into error completions.
module periph_bus_bridge #(
    parameter int                     ADDR_W      = 30,
    parameter int                     REGION_BITS = 8,
    parameter logic [REGION_BITS-1:0] REGION_VAL  = 8'hF0,
    parameter int                     SEL_BITS    = 4,
    parameter int                     NUM_PERIPH  = 4,
    parameter int                     TIMEOUT     = 255
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [ADDR_W-1:0]       i_AV_Addr,
    input  logic [3:0]              i_AV_ByteEn,
    input  logic                    i_AV_Read,
    input  logic                    i_AV_Write,
    input  logic [31:0]             i_AV_WriteData,
    output logic [31:0]             o_AV_ReadData,
    output logic                    o_AV_WaitRequest,
    output logic [ADDR_W-1:0]       o_PERIPH_Addr,
    output logic [3:0]              o_PERIPH_ByteEn,
    output logic                    o_PERIPH_Read,
    output logic                    o_PERIPH_Write,
    output logic [31:0]             o_PERIPH_WriteData,
    output logic [7:0]              o_PERIPH_BurstCount,
    input  logic [32*NUM_PERIPH-1:0] i_PERIPH_ReadData,
    input  logic [NUM_PERIPH-1:0]   i_PERIPH_WaitReq,
    output logic                    o_BusError,
    output logic [ADDR_W-1:0]       o_ErrAddr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ERR,
        S_DONE
    } state_t;

    state_t                r_State;
    state_t                w_NextState;
    logic [ADDR_W-1:0]     r_Addr;
    logic [3:0]            r_ByteEn;
    logic [31:0]           r_WriteData;
    logic [31:0]           r_ReadData;
    logic [SEL_BITS-1:0]   r_Sel;
    logic                  r_Read;
    logic                  r_Write;
    logic [7:0]            r_Count;
    logic                  r_BusError;
    logic [ADDR_W-1:0]     r_ErrAddr;

    logic                  w_Req;
    logic                  w_RegionHit;
    logic [SEL_BITS-1:0]   w_SelIn;
    logic                  w_Mapped;
    logic                  w_Timeout;
    logic                  w_SelWait;
    logic [31:0]           w_SelRData;

    assign w_Req       = i_AV_Read | i_AV_Write;
    assign w_RegionHit = (i_AV_Addr[ADDR_W-1 -: REGION_BITS] == REGION_VAL);
    assign w_SelIn     = i_AV_Addr[ADDR_W-REGION_BITS-1 -: SEL_BITS];
    assign w_Mapped    = w_RegionHit && ({1'b0, w_SelIn} < (SEL_BITS+1)'(NUM_PERIPH));
    assign w_Timeout   = (r_Count == 8'(TIMEOUT - 1));

    // Only the latched peripheral is listened to; everyone else's wait is ignored.
    always_comb begin
        w_SelWait  = 1'b1;
        w_SelRData = '0;
        for (int k = 0; k < NUM_PERIPH; k++) begin
            if (r_Sel == SEL_BITS'(k)) begin
                w_SelWait  = i_PERIPH_WaitReq[k];
                w_SelRData = i_PERIPH_ReadData[32*k +: 32];
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            S_IDLE: begin
                if (w_Req) begin
                    w_NextState = w_Mapped ? S_BUSY : S_ERR;
                end
            end
            S_BUSY: begin
                if (!w_SelWait) begin
                    w_NextState = S_DONE;
                end else if (w_Timeout) begin
                    w_NextState = S_ERR;
                end
            end
            S_ERR:   w_NextState = S_DONE;
            S_DONE:  w_NextState = S_IDLE;
            default: w_NextState = S_IDLE;
        endcase
    end

    // Read wins when the CPU raises both strobes, so the write strobe only follows a pure write.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Addr      <= '0;
            r_ByteEn    <= '0;
            r_WriteData <= '0;
            r_ReadData  <= '0;
            r_Sel       <= '0;
            r_Read      <= 1'b0;
            r_Write     <= 1'b0;
            r_Count     <= '0;
            r_BusError  <= 1'b0;
            r_ErrAddr   <= '0;
        end else begin
            r_BusError <= (w_NextState == S_ERR);
            case (r_State)
                S_IDLE: begin
                    if (w_Req) begin
                        if (w_Mapped) begin
                            r_Addr      <= i_AV_Addr;
                            r_ByteEn    <= i_AV_ByteEn;
                            r_WriteData <= i_AV_WriteData;
                            r_Sel       <= w_SelIn;
                            r_Read      <= i_AV_Read;
                            r_Write     <= ~i_AV_Read;
                            r_Count     <= '0;
                        end else begin
                            r_ErrAddr <= i_AV_Addr;
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_SelWait) begin
                        r_ReadData <= r_Read ? w_SelRData : 32'h0;
                        r_Read     <= 1'b0;
                        r_Write    <= 1'b0;
                    end else if (w_Timeout) begin
                        r_Read    <= 1'b0;
                        r_Write   <= 1'b0;
                        r_ErrAddr <= r_Addr;
                    end else begin
                        r_Count <= r_Count + 8'd1;
                    end
                end
                S_ERR: begin
                    r_ReadData <= 32'h0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_AV_ReadData       = r_ReadData;
    assign o_AV_WaitRequest    = (r_State != S_DONE);
    assign o_PERIPH_Addr       = r_Addr;
    assign o_PERIPH_ByteEn     = r_ByteEn;
    assign o_PERIPH_Read       = r_Read;
    assign o_PERIPH_Write      = r_Write;
    assign o_PERIPH_WriteData  = r_WriteData;
    assign o_PERIPH_BurstCount = 8'd1;
    assign o_BusError          = r_BusError;
    assign o_ErrAddr           = r_ErrAddr;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Scoreboard bench for periph_bus_bridge: directed accesses push expected completions,
// a negedge monitor pops and compares them whenever the bridge completes.
module tb_periph_bus_bridge;

    localparam int NP = 4;

    logic          i_Clk;
    logic          i_Reset;
    logic [29:0]   i_AV_Addr;
    logic [3:0]    i_AV_ByteEn;
    logic          i_AV_Read;
    logic          i_AV_Write;
    logic [31:0]   i_AV_WriteData;
    logic [31:0]   o_AV_ReadData;
    logic          o_AV_WaitRequest;
    logic [29:0]   o_PERIPH_Addr;
    logic [3:0]    o_PERIPH_ByteEn;
    logic          o_PERIPH_Read;
    logic          o_PERIPH_Write;
    logic [31:0]   o_PERIPH_WriteData;
    logic [7:0]    o_PERIPH_BurstCount;
    logic [32*NP-1:0] i_PERIPH_ReadData;
    logic [NP-1:0] i_PERIPH_WaitReq;
    logic          o_BusError;
    logic [29:0]   o_ErrAddr;

    periph_bus_bridge #(
        .ADDR_W(30), .REGION_BITS(8), .REGION_VAL(8'hF0),
        .SEL_BITS(4), .NUM_PERIPH(NP), .TIMEOUT(8)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_AV_Addr(i_AV_Addr), .i_AV_ByteEn(i_AV_ByteEn),
        .i_AV_Read(i_AV_Read), .i_AV_Write(i_AV_Write),
        .i_AV_WriteData(i_AV_WriteData), .o_AV_ReadData(o_AV_ReadData),
        .o_AV_WaitRequest(o_AV_WaitRequest), .o_PERIPH_Addr(o_PERIPH_Addr),
        .o_PERIPH_ByteEn(o_PERIPH_ByteEn), .o_PERIPH_Read(o_PERIPH_Read),
        .o_PERIPH_Write(o_PERIPH_Write), .o_PERIPH_WriteData(o_PERIPH_WriteData),
        .o_PERIPH_BurstCount(o_PERIPH_BurstCount), .i_PERIPH_ReadData(i_PERIPH_ReadData),
        .i_PERIPH_WaitReq(i_PERIPH_WaitReq), .o_BusError(o_BusError),
        .o_ErrAddr(o_ErrAddr)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        int          rdN;
        int          wrN;
        int          issue;
    } exp_t;

    exp_t sbQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycCount = 0;
    int   waitLeft = 0;
    bit   stuck = 0;
    bit   toggle = 0;
    int   monRd = 0;
    int   monWr = 0;
    int   monErr = 0;
    int   selIdx;
    logic [NP-1:0] pw;
    exp_t popped;

    always @(posedge i_Clk) cycCount <= cycCount + 1;

    function automatic logic [29:0] mkAddr(input logic [7:0] region, input logic [3:0] sel,
                                           input logic [17:0] low);
        mkAddr = {region, sel, low};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Peripheral model: selected peripheral waits as told, the others hold wait high.
    always @(negedge i_Clk) begin
        if (o_PERIPH_Read || o_PERIPH_Write) begin
            selIdx = int'(o_PERIPH_Addr[21:18]);
            pw = '1;
            if (stuck) begin
                pw[selIdx] = 1'b1;
            end else if (waitLeft > 0) begin
                pw[selIdx] = 1'b1;
                waitLeft--;
            end else begin
                pw[selIdx] = 1'b0;
            end
        end else if (toggle) begin
            pw = {{(NP-1){1'b0}}, ~i_PERIPH_WaitReq[0]};
        end else begin
            pw = '0;
        end
        i_PERIPH_WaitReq = pw;
    end

    always @(negedge i_Clk) begin
        if (i_Reset) begin
            monRd = 0;
            monWr = 0;
            monErr = 0;
        end else begin
            if (o_PERIPH_Read || o_PERIPH_Write) begin
                if (monRd + monWr == 0 && sbQ.size() > 0) begin
                    checkOutput("periph_addr", 64'(o_PERIPH_Addr), 64'(sbQ[0].addr));
                    checkOutput("periph_byteen", 64'(o_PERIPH_ByteEn), 64'(sbQ[0].be));
                    checkOutput("periph_wdata", 64'(o_PERIPH_WriteData), 64'(sbQ[0].wdata));
                    checkOutput("burstcount", 64'(o_PERIPH_BurstCount), 64'd1);
                end
                if (o_PERIPH_Read) monRd++;
                if (o_PERIPH_Write) monWr++;
            end
            if (o_BusError) monErr++;
            if (!o_AV_WaitRequest) begin
                if (sbQ.size() == 0) begin
                    checkOutput("spurious_done", 64'd1, 64'd0);
                end else begin
                    popped = sbQ.pop_front();
                    checkOutput("readdata", 64'(o_AV_ReadData), 64'(popped.rdata));
                    checkOutput("latency", 64'(cycCount - popped.issue + 1), 64'(popped.lat));
                    checkOutput("read_strobes", 64'(monRd), 64'(popped.rdN));
                    checkOutput("write_strobes", 64'(monWr), 64'(popped.wrN));
                    checkOutput("buserr_pulses", 64'(monErr), popped.err ? 64'd1 : 64'd0);
                    if (popped.err) checkOutput("erraddr", 64'(o_ErrAddr), 64'(popped.addr));
                end
                monRd = 0;
                monWr = 0;
                monErr = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [29:0] addr, input bit rd, input bit wr,
                                 input logic [3:0] be, input logic [31:0] wd,
                                 input int waitN, input bit stk, input bit tog,
                                 input logic [31:0] expRdata, input bit expErr,
                                 input int expLat, input int expRd, input int expWr);
        exp_t e;
        bit done;
        @(posedge i_Clk);
        #1;
        e.addr = addr; e.be = be; e.wdata = wd; e.rdata = expRdata; e.err = expErr;
        e.lat = expLat; e.rdN = expRd; e.wrN = expWr; e.issue = cycCount;
        sbQ.push_back(e);
        waitLeft = waitN;
        stuck = stk;
        toggle = tog;
        i_AV_Addr = addr;
        i_AV_Read = rd;
        i_AV_Write = wr;
        i_AV_ByteEn = be;
        i_AV_WriteData = wd;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge i_Clk);
            if (!o_AV_WaitRequest) done = 1;
        end
        if (!done) checkOutput("completion_timeout", 64'd0, 64'd1);
        @(posedge i_Clk);
        #1;
        i_AV_Read = 1'b0;
        i_AV_Write = 1'b0;
        stuck = 0;
        toggle = 0;
        waitLeft = 0;
    endtask

    initial begin
        i_Reset = 1'b1;
        i_AV_Addr = '0;
        i_AV_ByteEn = '0;
        i_AV_Read = 1'b0;
        i_AV_Write = 1'b0;
        i_AV_WriteData = '0;
        i_PERIPH_ReadData = {32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678};
        i_PERIPH_WaitReq = '0;
        repeat (3) @(posedge i_Clk);
        #1;
        checkOutput("rst_waitreq", 64'(o_AV_WaitRequest), 64'd1);
        checkOutput("rst_read", 64'(o_PERIPH_Read), 64'd0);
        checkOutput("rst_write", 64'(o_PERIPH_Write), 64'd0);
        checkOutput("rst_rdata", 64'(o_AV_ReadData), 64'd0);
        checkOutput("rst_buserr", 64'(o_BusError), 64'd0);
        checkOutput("rst_erraddr", 64'(o_ErrAddr), 64'd0);
        checkOutput("rst_addr", 64'(o_PERIPH_Addr), 64'd0);
        i_Reset = 1'b0;

        applyStimulus(mkAddr(8'hF0, 4'd0, 18'h00010), 1, 0, 4'hF, 32'h0, 0, 0, 0,
                      32'h12345678, 0, 3, 1, 0);
        applyStimulus(mkAddr(8'h00, 4'd0, 18'h00040), 1, 0, 4'hF, 32'h0, 0, 0, 0,
                      32'h0, 1, 3, 0, 0);
        applyStimulus(mkAddr(8'hF0, 4'd1, 18'h00004), 0, 1, 4'b0011, 32'h0000A5A5, 4, 0, 0,
                      32'h0, 0, 7, 0, 5);
        applyStimulus(mkAddr(8'hF0, 4'd4, 18'h00008), 1, 0, 4'hF, 32'h0, 0, 0, 1,
                      32'h0, 1, 3, 0, 0);
        applyStimulus(mkAddr(8'hF0, 4'd2, 18'h0000C), 1, 1, 4'hF, 32'h55AA55AA, 1, 0, 0,
                      32'hCAFEF00D, 0, 4, 2, 0);
        applyStimulus(mkAddr(8'hF0, 4'd3, 18'h00020), 1, 0, 4'hF, 32'h0, 0, 1, 0,
                      32'h0, 1, 11, 8, 0);

        // Reset lands two cycles into BUSY with the peripheral hung.
        @(posedge i_Clk);
        #1;
        stuck = 1;
        i_AV_Addr = mkAddr(8'hF0, 4'd0, 18'h00030);
        i_AV_ByteEn = 4'hF;
        i_AV_Read = 1'b1;
        repeat (2) @(posedge i_Clk);
        #1;
        checkOutput("busy_strobe", 64'(o_PERIPH_Read), 64'd1);
        i_Reset = 1'b1;
        @(posedge i_Clk);
        #1;
        checkOutput("midrst_read", 64'(o_PERIPH_Read), 64'd0);
        checkOutput("midrst_waitreq", 64'(o_AV_WaitRequest), 64'd1);
        checkOutput("midrst_erraddr", 64'(o_ErrAddr), 64'd0);
        i_AV_Read = 1'b0;
        stuck = 0;
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b0;

        applyStimulus(mkAddr(8'hF0, 4'd0, 18'h00010), 1, 0, 4'hF, 32'h0, 2, 0, 0,
                      32'h12345678, 0, 5, 3, 0);

        repeat (3) @(posedge i_Clk);
        checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
